// File: rtl/decode_pipe.sv
// Registered RV32I decode stage with a 2-entry (OUT + SKID) valid/ready buffer and flush.
// Optional illegal-opcode detection is compiled in with `define DECODE_ILLEGAL_EN.
module decode_pipe #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [DWIDTH-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o,
  output logic [1:0]        state_dbg
);

  // Handshake: an input transfer happens on a clock edge where valid_i && ready_o,
  // an output transfer where valid_o && ready_i; ready_o never depends on ready_i.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              ready_q;
  logic [DWIDTH-1:0] insn_r, skid_insn, new_insn, imm_r, new_imm;
  logic [AWIDTH-1:0] pc_r, skid_pc, new_pc;
  logic              accept, drain;
  logic              load_in, load_skid, skid_to_out, clear_out;

  function automatic logic [DWIDTH-1:0] imm_of(input logic [DWIDTH-1:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b1110011: imm_of = {{20{i[31]}}, i[31:20]};
      7'b0100011:             imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:             imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm_of = {i[31:12], 12'b0};
      7'b1101111:             imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                imm_of = '0;
    endcase
  endfunction

`ifdef DECODE_ILLEGAL_EN
  logic illegal_r, new_illegal;

  function automatic logic is_illegal(input logic [DWIDTH-1:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b0110011, 7'b0001111: is_illegal = (i[1:0] != 2'b11);
      default:                             is_illegal = 1'b1;
    endcase
  endfunction
`endif

  assign accept = valid_i && ready_q;
  assign drain  = (state != EMPTY) && ready_i;

  always_comb begin
    state_nxt   = state;
    load_in     = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    clear_out   = 1'b0;
    if (flush_i) begin
      state_nxt = EMPTY;
      clear_out = 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nxt = ONE;
          load_in   = 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            load_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nxt = EMPTY;
            clear_out = 1'b1;
          end
        end
        FULL: if (drain) begin
          state_nxt   = ONE;
          skid_to_out = 1'b1;
        end
        default: begin
          state_nxt = EMPTY;
          clear_out = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    new_insn = skid_to_out ? skid_insn : insn_i;
    new_pc   = skid_to_out ? skid_pc : pc_i;
`ifdef DECODE_ILLEGAL_EN
    new_illegal = is_illegal(new_insn);
    new_imm     = new_illegal ? '0 : imm_of(new_insn);
`else
    new_imm     = imm_of(new_insn);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != FULL);
    end
  end

  // pc_r is deliberately left untouched when OUT empties so pc_o keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      insn_r    <= NOP_INSN;
      pc_r      <= '0;
      imm_r     <= imm_of(NOP_INSN);
      skid_insn <= '0;
      skid_pc   <= '0;
    end else begin
      if (load_in || skid_to_out) begin
        insn_r <= new_insn;
        pc_r   <= new_pc;
        imm_r  <= new_imm;
      end else if (clear_out) begin
        insn_r <= NOP_INSN;
        imm_r  <= imm_of(NOP_INSN);
      end
      if (load_skid) begin
        skid_insn <= insn_i;
        skid_pc   <= pc_i;
      end
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        illegal_r <= 1'b0;
    else if (load_in || skid_to_out) illegal_r <= new_illegal;
    else if (clear_out)             illegal_r <= 1'b0;
  end
  assign illegal_o = illegal_r;
`else
  assign illegal_o = 1'b0;
`endif

  assign ready_o   = ready_q;
  assign valid_o   = (state != EMPTY);
  assign state_dbg = state;
  assign insn_o    = insn_r;
  assign pc_o      = pc_r;
  assign imm_o     = imm_r;
  assign opcode_o  = insn_r[6:0];
  assign rd_o      = insn_r[11:7];
  assign funct3_o  = insn_r[14:12];
  assign rs1_o     = insn_r[19:15];
  assign rs2_o     = insn_r[24:20];
  assign funct7_o  = insn_r[31:25];
  assign shamt_o   = insn_r[24:20];

endmodule
